// File: rtl/manch_demod_if.sv
// rtl/manch_demod_if.sv - decoded-bit strobe bundle from manch_demod to the frame deframer
interface manch_demod_if;
  logic out_data;
  logic out_valid;
  logic out_sof;
  logic out_eof;
  logic out_err;
  logic out_busy;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    output out_err,
    output out_busy
  );

  modport slave (
    input out_data,
    input out_valid,
    input out_sof,
    input out_eof,
    input out_err,
    input out_busy
  );
endinterface

// File: rtl/manch_demod.sv
// rtl/manch_demod.sv - Manchester decoder for the ISO 14443-A 106 kb/s tag-to-reader link
// Counts subcarrier toggles per half-ETU window; window phase is fixed by the first SOF edge.
module manch_demod #(
  parameter int OSR      = 8,
  parameter int SUB_HALF = 4,
  parameter int EDGE_MIN = 5
) (
  input  logic          clk,
  input  logic          in_rst_n,
  input  logic          in_enable,
  input  logic          in_data,
  manch_demod_if.master out_if
);

  localparam int HALF = OSR * SUB_HALF;
  localparam int HW   = $clog2(HALF);
  localparam int TW   = $clog2(HALF + 1);

  typedef enum logic [2:0] {
    IDLE,
    SOF_H1,
    SOF_H2,
    D_H1,
    D_H2
  } state_t;

  state_t        state, state_n;
  logic          sync1, sync2, prev;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          a1, a1_n;
  logic          data_q, data_n;
  logic          valid_q, valid_n;
  logic          sof_q, sof_n;
  logic          eof_q, eof_n;
  logic          err_q, err_n;
  logic          busy_q, busy_n;
  logic          toggle;
  logic          win_end;
  logic          active;
  logic [TW:0]   tsum;

  // Synchronizer idles at the unmodulated line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!in_rst_n || !in_enable) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= in_data;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign toggle  = sync2 ^ prev;
  assign win_end = (hcnt == HW'(HALF - 1));
  // The toggle on the boundary cycle still belongs to the closing window.
  assign tsum    = {1'b0, tcnt} + {{TW{1'b0}}, toggle};
  assign active  = (tsum >= (TW + 1)'(EDGE_MIN));

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    tcnt_n  = tcnt;
    a1_n    = a1;
    data_n  = data_q;
    busy_n  = busy_q;
    valid_n = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    err_n   = 1'b0;

    if (state != IDLE) begin
      hcnt_n = win_end ? '0 : hcnt + 1'b1;
      if (win_end)
        tcnt_n = '0;
      else if (toggle && (tcnt != TW'(HALF)))
        tcnt_n = tcnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (toggle) begin
          hcnt_n  = HW'(1);
          tcnt_n  = TW'(1);
          state_n = SOF_H1;
        end
      end
      SOF_H1: begin
        if (win_end)
          state_n = active ? SOF_H2 : IDLE;
      end
      SOF_H2: begin
        if (win_end) begin
          if (active) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            sof_n   = 1'b1;
            busy_n  = 1'b1;
            state_n = D_H1;
          end
        end
      end
      D_H1: begin
        if (win_end) begin
          a1_n    = active;
          state_n = D_H2;
        end
      end
      D_H2: begin
        if (win_end) begin
          case ({a1, active})
            2'b10: begin
              data_n  = 1'b1;
              valid_n = 1'b1;
              state_n = D_H1;
            end
            2'b01: begin
              data_n  = 1'b0;
              valid_n = 1'b1;
              state_n = D_H1;
            end
            2'b00: begin
              eof_n   = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end
            default: begin
              err_n   = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n || !in_enable) begin
      state   <= IDLE;
      hcnt    <= '0;
      tcnt    <= '0;
      a1      <= 1'b0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      tcnt    <= tcnt_n;
      a1      <= a1_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_sof   = sof_q;
  assign out_if.out_eof   = eof_q;
  assign out_if.out_err   = err_q;
  assign out_if.out_busy  = busy_q;

endmodule

// File: tb/tb_manch_demod.sv
// tb/tb_manch_demod.sv - table-driven scoreboard bench for manch_demod
module tb_manch_demod;

  localparam int ETU    = 64;
  localparam int K_NONE = 0;
  localparam int K_SOF  = 1;
  localparam int K_VAL  = 2;
  localparam int K_EOF  = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int n1;
    int n2;
    int kind;
    bit data;
  } vec_t;

  typedef struct {
    int kind;
    bit data;
    int cyc;
  } exp_t;

  logic clk       = 1'b0;
  logic in_rst_n  = 1'b0;
  logic in_enable = 1'b0;
  logic in_data   = 1'b1;
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  exp_t sb[$];
  vec_t tbl[$];

  manch_demod_if dif ();

  manch_demod dut (
    .clk       (clk),
    .in_rst_n  (in_rst_n),
    .in_enable (in_enable),
    .in_data   (in_data),
    .out_if    (dif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input int n1, input int n2, input int kind, input bit d);
    vec_t v;
    v.n1 = n1;
    v.n2 = n2;
    v.kind = kind;
    v.data = d;
    return v;
  endfunction

  // Strobes are compared against the scoreboard: kind, exact cycle, data and busy level.
  always @(negedge clk) begin : mon
    int   k;
    int   nstr;
    exp_t e;
    nstr = int'(dif.out_sof) + int'(dif.out_valid) + int'(dif.out_eof) + int'(dif.out_err);
    if (nstr != 0) begin
      k = dif.out_sof ? K_SOF : dif.out_valid ? K_VAL : dif.out_eof ? K_EOF : K_ERR;
      check("strobe_exclusive", nstr, 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", k, K_NONE);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", k, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        if (k == K_VAL) check("out_data", int'(dif.out_data), int'(e.data));
        check("busy_at_strobe", int'(dif.out_busy), (k == K_SOF || k == K_VAL) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_half(input int n);
    for (int i = 0; i < ETU / 2; i++) begin
      tick();
      if ((i % 4 == 0) && (i / 4 < n)) in_data = ~in_data;
    end
  endtask

  // ETU starts on the next edge; 2 sync cycles plus one ETU plus one register stage.
  task automatic run_vec(input vec_t v);
    exp_t e;
    if (v.kind != K_NONE) begin
      e.kind = v.kind;
      e.data = v.data;
      e.cyc  = cyc + 1 + 2 + ETU;
      sb.push_back(e);
    end
    drive_half(v.n1);
    drive_half(v.n2);
  endtask

  initial begin : main
    int bad;

    tbl.push_back(mk(8, 0, K_SOF, 1'b0));
    tbl.push_back(mk(8, 0, K_VAL, 1'b1));
    tbl.push_back(mk(0, 8, K_VAL, 1'b0));
    tbl.push_back(mk(8, 0, K_VAL, 1'b1));
    tbl.push_back(mk(8, 0, K_VAL, 1'b1));
    tbl.push_back(mk(0, 8, K_VAL, 1'b0));
    tbl.push_back(mk(0, 8, K_VAL, 1'b0));
    tbl.push_back(mk(8, 0, K_VAL, 1'b1));
    tbl.push_back(mk(0, 8, K_VAL, 1'b0));
    tbl.push_back(mk(0, 0, K_EOF, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(8, 0, K_SOF, 1'b0));
    tbl.push_back(mk(5, 0, K_VAL, 1'b1));
    tbl.push_back(mk(8, 8, K_ERR, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(8, 0, K_SOF, 1'b0));
    tbl.push_back(mk(4, 0, K_EOF, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(8, 8, K_ERR, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(3, 0, K_NONE, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(8, 0, K_SOF, 1'b0));
    tbl.push_back(mk(0, 5, K_VAL, 1'b0));
    tbl.push_back(mk(0, 0, K_EOF, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));
    tbl.push_back(mk(8, 0, K_SOF, 1'b0));
    tbl.push_back(mk(0, 4, K_EOF, 1'b0));
    tbl.push_back(mk(0, 0, K_NONE, 1'b0));

    for (int i = 0; i < 4; i++) begin
      tick();
      in_data = ~in_data;
      check("reset_outputs", int'({dif.out_sof, dif.out_valid, dif.out_eof,
                                   dif.out_err, dif.out_busy, dif.out_data}), 0);
    end
    in_data   = 1'b1;
    in_rst_n  = 1'b1;
    in_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dif.out_busy || dif.out_data) bad++;
    end
    check("idle_quiet", bad, 0);

    bad = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (i == 0 || i == 10 || i == 20 || i == 60) in_data = ~in_data;
      if (dif.out_busy) bad++;
    end
    check("noise_busy", bad, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    run_vec(mk(8, 0, K_SOF, 1'b0));
    run_vec(mk(8, 0, K_VAL, 1'b1));
    run_vec(mk(0, 8, K_VAL, 1'b0));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 4 == 0) in_data = ~in_data;
    end
    check("busy_mid_frame", int'(dif.out_busy), 1);
    tick();
    in_enable = 1'b0;
    in_data   = 1'b1;
    tick();
    check("abort_busy", int'(dif.out_busy), 0);
    for (int i = 0; i < 10; i++) tick();
    in_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dif.out_busy) bad++;
    end
    check("post_abort_idle", bad, 0);

    run_vec(mk(8, 0, K_SOF, 1'b0));
    run_vec(mk(0, 8, K_VAL, 1'b0));
    run_vec(mk(8, 0, K_VAL, 1'b1));
    run_vec(mk(0, 0, K_EOF, 1'b0));
    for (int i = 0; i < 20; i++) tick();
    check("final_busy", int'(dif.out_busy), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/manch_demod.md
Name: manch_demod

Overview:
- Manchester decoder for the 106 kb/s ISO 14443-A tag-to-reader link; the receive-side counterpart of the team's Manchester encoder.
- Each ETU has two halves. The modulated half carries the fc/16 subcarrier; the unmodulated half is constant high.
  - Logic 1: subcarrier in the first half.
  - Logic 0: subcarrier in the second half.
- The block oversamples the demodulated subcarrier line, recovers SOF, data bits and EOF, and hands bits to the frame deframer.

Parameters:
- OSR, 8, clk cycles per subcarrier period (clk = fc/2 when OSR=8)
- SUB_HALF, 4, subcarrier periods per half-ETU
- EDGE_MIN, 5, minimum input toggles in a half-window for it to count as "active" (ideal count is 2*SUB_HALF = 8)

Ports:
- clk  input  1  oversampling clock
- in_rst_n  input  1  synchronous active-low reset
- in_enable  input  1  module enable; low forces IDLE synchronously, same effect as reset
- in_data  input  1  subcarrier line from the analog front end, asynchronous
- out_data  output  1  decoded bit, valid while out_valid=1
- out_valid  output  1  one-cycle strobe per decoded data bit
- out_sof  output  1  one-cycle strobe when SOF is confirmed
- out_eof  output  1  one-cycle strobe at end of frame
- out_err  output  1  one-cycle strobe on a coding violation or collision
- out_busy  output  1  high from SOF detection until return to IDLE

Behaviour:
- Clock and reset:
  - Single clock; all state updates on posedge clk.
  - Reset is synchronous and active-low on in_rst_n.
  - in_enable=0 has the same effect as reset.
- Reset values: all outputs 0; state IDLE; counters 0; synchronizer flops 1 (idle line level).
- Input conditioning:
  - in_data passes through a 2-flop synchronizer, then one more flop for edge detection.
  - toggle = sync XOR prev.
  - Synchronizer latency is 2 cycles; all timing below is relative to the synchronized signal.
- Derived constants:
  - HALF = OSR*SUB_HALF (default 32).
  - hcnt: half-window counter, width clog2(HALF), runs 0..HALF-1 and wraps.
  - tcnt: toggle counter, width clog2(HALF+1), saturating.
- IDLE:
  - Waits for the first toggle; out_busy=0.
  - On a toggle: hcnt<=1, tcnt<=1, go to SOF_H1.
- SOF_H1 (first half of SOF, must be active):
  - At hcnt=HALF-1, evaluate active = (tcnt+toggle >= EDGE_MIN).
  - If inactive: return to IDLE silently, with no strobe (noise rejection).
  - If active: go to SOF_H2.
- SOF_H2 (must be inactive):
  - If inactive at window end: out_sof=1 for one cycle, out_busy<=1, go to D_H1.
  - If active: out_err=1, go to IDLE.
- D_H1 and D_H2: count toggles per half-window. At the end of D_H2, the (a1, a2) pair gives:
  - (1,0): out_data=1, out_valid=1.
  - (0,1): out_data=0, out_valid=1.
  - (0,0): out_eof=1, go to IDLE.
  - (1,1): out_err=1 (collision), go to IDLE.
  - Otherwise, continue to D_H1.
- Strobe timing:
  - Strobes fire in the cycle after the last sample of the ETU.
  - Latency is 1 clk after the window end; no bit is emitted mid-ETU.
- Window handling:
  - tcnt clears at each window boundary; the boundary-cycle toggle is counted in the closing window.
  - No drift tracking: window alignment is fixed by the first SOF edge for the whole frame.
- Simultaneous events and mid-frame control:
  - Reset or in_enable=0 has priority over every strobe. Strobes in the same cycle are suppressed and the frame is discarded without out_eof.
  - out_sof, out_valid, out_eof and out_err are mutually exclusive in any cycle.
  - out_data holds its last value when out_valid=0.
- Bit ordering: the decoder does none; bits are emitted in arrival order.

Test Plan:
- Reset/idle: in_rst_n=0 for 4 clks, with in_data toggling and then held at 1 for 200 clks → all outputs 0, out_busy=0 throughout.
- Noise rejection: 3 isolated toggles within 32 clks, then line high → no out_sof or out_err, state returns to IDLE (out_busy stays 0).
- Clean frame:
  - Stimulus: SOF, then bits 1,0,1,1,0,0,1,0, then one idle ETU (64 clks high), using the encoder's waveform at OSR=8.
  - Required response: out_sof once, 64+2 clks after the first edge; 8 out_valid pulses spaced exactly 64 clks apart, with out_data = 1,0,1,1,0,0,1,0; out_eof 64 clks after the last bit; then out_busy=0.
- Collision: a data ETU with subcarrier in both halves → out_err pulse at that ETU's end, no out_valid for it, out_busy drops the next cycle.
- Marginal edge count: a half-window with exactly 5 toggles counts as active and decodes correctly; one with 4 toggles counts as inactive (for the test bit, that case yields out_eof).
- Abort: in_enable driven low in cycle 20 of the third data ETU → no further strobes, out_busy=0 the next cycle; a new frame afterwards decodes normally.
